rgb_ramp: RTL and testbench

Multi-channel keyframe ramp generator with built-in PWM output. It drives N_CH LED channels through N_STAGES keyframes, moving each channel's duty linearly between full-off and full-on. It supports pause, loop or one-shot playback, and synchronous restart. It sits between the top-level clock/reset and the LED pins, and replaces the earlier single-channel fixed-rate ramp.

---
 rtl/rgb_ramp.sv | 217 +++++++++++++++++++++
 tb/tb_rgb_ramp.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_ramp.sv
// ---------------------------------------------------------------------------
// rgb_ramp
//
// Multi-channel keyframe ramp generator with built-in PWM. Each of N_CH LED
// channels walks through N_STAGES keyframes. At every keyframe a channel is
// either fully off (0) or fully on (DUTY_MAX). Between keyframes the duty
// moves one step toward the next keyframe level every SUBSTEP cycles. At the
// stage boundary it snaps to that level exactly. A free-running PWM counter
// turns each duty into a registered waveform.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high; full reset including PWM
//   en         in   1 = ramp advances, 0 = ramp frozen (PWM keeps running)
//   one_shot   in   0 = loop forever, 1 = stop after the last stage
//   restart    in   synchronous pulse; ramp back to its reset state, PWM
//                   counter untouched
//   duty       out  current duty, channel c at [c*DW +: DW]
//   pwm_out    out  registered PWM waveform per channel
//   stage      out  current stage index
//   stage_tick out  one-cycle pulse on every stage boundary taken
//   done       out  high while the one-shot pattern has finished
//
// State    | meaning
// ---------+----------------------------------------------------------------
// ST_RUN   | ramp active; counters advance while en = 1
// ST_DONE  | one-shot pattern finished; ramp frozen until restart/reset
// ---------------------------------------------------------------------------
module rgb_ramp #(
    parameter int N_CH         = 3,
    parameter int N_STAGES     = 7,
    parameter int STAGE_CYCLES = 2000000,
    parameter int DUTY_MAX     = 100,
    parameter logic [N_CH*N_STAGES-1:0] PATTERN = {N_CH{7'b0011100}},
    localparam int DW = $clog2(DUTY_MAX + 1),
    localparam int SW = ($clog2(N_STAGES) > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               one_shot,
    input  logic               restart,
    output logic [N_CH*DW-1:0] duty,
    output logic [N_CH-1:0]    pwm_out,
    output logic [SW-1:0]      stage,
    output logic               stage_tick,
    output logic               done
);

    localparam int SUBSTEP = STAGE_CYCLES / DUTY_MAX;
    localparam int CW = ($clog2(STAGE_CYCLES) > 1) ? $clog2(STAGE_CYCLES) : 1;
    localparam int BW = ($clog2(SUBSTEP) > 1) ? $clog2(SUBSTEP) : 1;

    localparam logic [CW-1:0] CYC_LAST   = CW'(STAGE_CYCLES - 1);
    localparam logic [BW-1:0] SUB_LAST   = BW'(SUBSTEP - 1);
    localparam logic [DW-1:0] DMAX       = DW'(DUTY_MAX);
    localparam logic [DW-1:0] PWM_LAST   = DW'(DUTY_MAX - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(N_STAGES - 1);

    // Keyframe levels of all channels at stage s, expanded to duty values.
    function automatic logic [N_CH*DW-1:0] levels_at(input int s);
        logic [N_CH*DW-1:0] v;
        v = '0;
        for (int c = 0; c < N_CH; c++) begin
            v[c*DW +: DW] = PATTERN[c*N_STAGES + s] ? DMAX : '0;
        end
        return v;
    endfunction

    // One substep toward the target. The target is always 0 or DMAX, so a
    // single step can never overshoot it.
    function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] cur,
                                                  input logic [DW-1:0] tgt);
        logic [DW-1:0] nxt;
        if (cur < tgt) begin
            nxt = cur + 1'b1;
        end else if (cur > tgt) begin
            nxt = cur - 1'b1;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    localparam logic [N_CH*DW-1:0] DUTY_INIT = levels_at(0);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      stage_q, stage_d;
    logic [CW-1:0]      cyc_q, cyc_d;
    logic [BW-1:0]      sub_q, sub_d;
    logic [N_CH*DW-1:0] duty_q, duty_d;
    logic               tick_q, tick_d;

    logic [DW-1:0]      pwm_cnt_q, pwm_cnt_d;
    logic [N_CH-1:0]    pwm_q, pwm_d;

    logic [SW-1:0]      tgt_stage;
    logic [N_CH*DW-1:0] tgt_duty;
    logic [N_CH*DW-1:0] step_duty;

    // The stage after the last one targets keyframe 0 so a looping pattern
    // closes on itself.
    always_comb begin
        tgt_stage = (stage_q == STAGE_LAST) ? '0 : stage_q + 1'b1;
        tgt_duty  = levels_at(int'(tgt_stage));
        step_duty = '0;
        for (int c = 0; c < N_CH; c++) begin
            step_duty[c*DW +: DW] = step_toward(duty_q[c*DW +: DW],
                                                tgt_duty[c*DW +: DW]);
        end
    end

    // Ramp FSM: next state and datapath. Restart outranks en, en outranks the
    // boundary, and the boundary outranks the substep.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cyc_d   = cyc_q;
        sub_d   = sub_q;
        duty_d  = duty_q;
        tick_d  = 1'b0;

        if (restart) begin
            state_d = ST_RUN;
            stage_d = '0;
            cyc_d   = '0;
            sub_d   = '0;
            duty_d  = DUTY_INIT;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (en) begin
                        if (cyc_q == CYC_LAST) begin
                            // A substep that lands on this edge is dropped;
                            // the snap already reaches the target.
                            cyc_d  = '0;
                            sub_d  = '0;
                            duty_d = tgt_duty;
                            tick_d = 1'b1;
                            if (stage_q != STAGE_LAST) begin
                                stage_d = stage_q + 1'b1;
                            end else if (!one_shot) begin
                                stage_d = '0;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            cyc_d = cyc_q + 1'b1;
                            if (sub_q == SUB_LAST) begin
                                sub_d  = '0;
                                duty_d = step_duty;
                            end else begin
                                sub_d = sub_q + 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    // Frozen until restart or reset.
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            stage_q <= '0;
            cyc_q   <= '0;
            sub_q   <= '0;
            duty_q  <= DUTY_INIT;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cyc_q   <= cyc_d;
            sub_q   <= sub_d;
            duty_q  <= duty_d;
            tick_q  <= tick_d;
        end
    end

    // PWM runs every cycle regardless of en, state or restart. With a period
    // of DUTY_MAX counts, duty 0 never fires and duty DUTY_MAX never drops.
    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
        pwm_d     = '0;
        for (int c = 0; c < N_CH; c++) begin
            pwm_d[c] = (pwm_cnt_q < duty_q[c*DW +: DW]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q <= '0;
            pwm_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            pwm_q     <= pwm_d;
        end
    end

    assign duty       = duty_q;
    assign pwm_out    = pwm_q;
    assign stage      = stage_q;
    assign stage_tick = tick_q;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_rgb_ramp.sv
// ---------------------------------------------------------------------------
// tb_rgb_ramp
//
// Directed bench for rgb_ramp with N_CH=3, N_STAGES=4, STAGE_CYCLES=20,
// DUTY_MAX=4 (SUBSTEP=5). Channel levels by stage: ch0 0,1,1,0;
// ch1 1,1,0,0; ch2 0,0,0,0. Stimulus queues hand-computed expectations
// tagged with the absolute edge they belong to. An independent monitor
// compares them on the falling edge after that rising edge.
// ---------------------------------------------------------------------------
module tb_rgb_ramp;

    localparam int N_CH         = 3;
    localparam int N_STAGES     = 4;
    localparam int STAGE_CYCLES = 20;
    localparam int DUTY_MAX     = 4;
    localparam logic [11:0] PAT = 12'b0000_0011_0110;
    localparam int DW = 3;
    localparam int SW = 2;

    localparam int K_DUTY  = 0;
    localparam int K_STAGE = 1;
    localparam int K_TICK  = 2;
    localparam int K_DONE  = 3;
    localparam int K_PWM   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic               one_shot;
    logic               restart;
    logic [N_CH*DW-1:0] duty;
    logic [N_CH-1:0]    pwm_out;
    logic [SW-1:0]      stage;
    logic               stage_tick;
    logic               done;

    rgb_ramp #(
        .N_CH        (N_CH),
        .N_STAGES    (N_STAGES),
        .STAGE_CYCLES(STAGE_CYCLES),
        .DUTY_MAX    (DUTY_MAX),
        .PATTERN     (PAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .one_shot  (one_shot),
        .restart   (restart),
        .duty      (duty),
        .pwm_out   (pwm_out),
        .stage     (stage),
        .stage_tick(stage_tick),
        .done      (done)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int at;
        int rel;
        int kind;
        int val;
        int tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   base   = 0;
    int   scen   = 0;

    function automatic string kname(input int k);
        case (k)
            K_DUTY:  return "duty";
            K_STAGE: return "stage";
            K_TICK:  return "stage_tick";
            K_DONE:  return "done";
            default: return "pwm_out";
        endcase
    endfunction

    function automatic int actual_of(input int k);
        case (k)
            K_DUTY:  return 32'(duty);
            K_STAGE: return 32'(stage);
            K_TICK:  return 32'(stage_tick);
            K_DONE:  return 32'(done);
            default: return 32'(pwm_out);
        endcase
    endfunction

    // duty packed as {ch2, ch1, ch0}
    function automatic int dv(input int a0, input int a1, input int a2);
        return (a2 << 6) | (a1 << 3) | a0;
    endfunction

    // Monitor: compares every expectation due on the edge just taken.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at <= edge_n) begin
                checks++;
                if (exp_q[i].at < edge_n) begin
                    errors++;
                    $display("FAIL %s s%0d edge %0d: check missed, required %0d",
                             kname(exp_q[i].kind), exp_q[i].tag, exp_q[i].rel, exp_q[i].val);
                end else if (actual_of(exp_q[i].kind) != exp_q[i].val) begin
                    errors++;
                    $display("FAIL %s s%0d edge %0d: got 0x%0h required 0x%0h",
                             kname(exp_q[i].kind), exp_q[i].tag, exp_q[i].rel,
                             actual_of(exp_q[i].kind), exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
    end

    task automatic expect_v(input int rel, input int kind, input int val);
        exp_t e;
        e.at   = base + rel;
        e.rel  = rel;
        e.kind = kind;
        e.val  = val;
        e.tag  = scen;
        exp_q.push_back(e);
    endtask

    task automatic st(input int rel, input int d, input int s, input int t, input int dn);
        expect_v(rel, K_DUTY, d);
        expect_v(rel, K_STAGE, s);
        expect_v(rel, K_TICK, t);
        expect_v(rel, K_DONE, dn);
    endtask

    task automatic wait_edge(input int abs_edge);
        while (edge_n < abs_edge) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds reset for three edges; edge 0 of the scenario is the last edge
    // that samples reset high. en rises right after it.
    task automatic start_run(input int tag, input logic os);
        scen     = tag;
        reset    = 1'b1;
        en       = 1'b0;
        restart  = 1'b0;
        one_shot = os;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        base = edge_n;
        st(0, dv(0, 4, 0), 0, 0, 0);
        expect_v(0, K_PWM, 0);
        reset = 1'b0;
        en    = 1'b1;
    endtask

    initial begin
        int guard;
        reset    = 1'b1;
        en       = 1'b0;
        one_shot = 1'b0;
        restart  = 1'b0;

        // Ramp up, PWM and loop wrap.
        start_run(1, 1'b0);
        expect_v(1, K_PWM, 3'b010);
        st(4,  dv(0, 4, 0), 0, 0, 0);
        st(5,  dv(1, 4, 0), 0, 0, 0);
        st(10, dv(2, 4, 0), 0, 0, 0);
        expect_v(11, K_PWM, 3'b010);
        expect_v(12, K_PWM, 3'b010);
        expect_v(13, K_PWM, 3'b011);
        expect_v(14, K_PWM, 3'b011);
        expect_v(15, K_PWM, 3'b010);
        st(15, dv(3, 4, 0), 0, 0, 0);
        st(19, dv(3, 4, 0), 0, 0, 0);
        st(20, dv(4, 4, 0), 1, 1, 0);
        st(21, dv(4, 4, 0), 1, 0, 0);
        st(25, dv(4, 3, 0), 1, 0, 0);
        st(40, dv(4, 0, 0), 2, 1, 0);
        st(45, dv(3, 0, 0), 2, 0, 0);
        st(60, dv(0, 0, 0), 3, 1, 0);
        st(65, dv(0, 1, 0), 3, 0, 0);
        st(80, dv(0, 4, 0), 0, 1, 0);
        st(81, dv(0, 4, 0), 0, 0, 0);
        wait_edge(base + 82);

        // One-shot: DONE, frozen, then reset out of DONE.
        start_run(2, 1'b1);
        st(79, dv(0, 3, 0), 3, 0, 0);
        st(80, dv(0, 4, 0), 3, 1, 1);
        for (int r = 81; r <= 180; r++) begin
            expect_v(r, K_TICK, 0);
        end
        st(130, dv(0, 4, 0), 3, 0, 1);
        st(180, dv(0, 4, 0), 3, 0, 1);
        wait_edge(base + 180);
        reset = 1'b1;
        st(181, dv(0, 4, 0), 0, 0, 0);
        expect_v(181, K_PWM, 0);
        wait_edge(base + 181);

        // Pause at edge 7 for 30 cycles, then finish stage 0.
        start_run(3, 1'b0);
        st(7,  dv(1, 4, 0), 0, 0, 0);
        st(20, dv(1, 4, 0), 0, 0, 0);
        st(37, dv(1, 4, 0), 0, 0, 0);
        st(40, dv(2, 4, 0), 0, 0, 0);
        st(49, dv(3, 4, 0), 0, 0, 0);
        st(50, dv(4, 4, 0), 1, 1, 0);
        st(51, dv(4, 4, 0), 1, 0, 0);
        wait_edge(base + 7);
        en = 1'b0;
        wait_edge(base + 37);
        en = 1'b1;
        wait_edge(base + 52);

        // Restart mid-stage, then restart on a boundary edge.
        start_run(4, 1'b0);
        st(11, dv(2, 4, 0), 0, 0, 0);
        st(12, dv(0, 4, 0), 0, 0, 0);
        st(16, dv(0, 4, 0), 0, 0, 0);
        st(17, dv(1, 4, 0), 0, 0, 0);
        st(31, dv(3, 4, 0), 0, 0, 0);
        st(32, dv(0, 4, 0), 0, 0, 0);
        st(33, dv(0, 4, 0), 0, 0, 0);
        st(37, dv(1, 4, 0), 0, 0, 0);
        wait_edge(base + 11);
        restart = 1'b1;
        wait_edge(base + 12);
        restart = 1'b0;
        wait_edge(base + 31);
        restart = 1'b1;
        wait_edge(base + 32);
        restart = 1'b0;
        wait_edge(base + 38);

        guard = 0;
        while (exp_q.size() > 0 && guard < 300) begin
            @(posedge clk);
            guard++;
        end
        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s s%0d edge %0d: never compared, required %0d",
                     kname(exp_q[0].kind), exp_q[0].tag, exp_q[0].rel, exp_q[0].val);
            void'(exp_q.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
